// File: rtl/nibble_add_seq.sv
// Sequencer for wide add/subtract using one 4-bit ripple slice per clock, LSB nibble first.
// Start/busy/done handshake; Q, cout and ovf are registered and update only when done rises.
module nibble_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   Q,
    output logic                   cout,
    output logic                   ovf
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    // Only the upper W-4 bits of R are kept; the newest nibble joins them on the way to Q.
    logic [W-5:0]    r_q, r_d;
    logic            carry_q, carry_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    q_q, q_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [4:0]      slice_sum;
    logic            slice_c3;
    logic [W-1:0]    r_shift;
    logic            capture;
    logic            last;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        capture = 1'b0;

        slice_sum = {1'b0, sa_q[3:0]} + {1'b0, sb_q[3:0]} + {4'b0, carry_q};
        // Carry into bit 3 recovered from the bit-3 sum: c3 = a3 ^ b3 ^ s3.
        slice_c3  = sa_q[3] ^ sb_q[3] ^ slice_sum[3];
        r_shift   = {slice_sum[3:0], r_q};
        last      = (cnt_q == CntW'(NIBBLES - 1));

        case (state_q)
            StIdle: begin
                if (start) capture = 1'b1;
            end
            StAdd: begin
                r_d     = r_shift[W-1:4];
                sa_d    = {4'b0, sa_q[W-1:4]};
                sb_d    = {4'b0, sb_q[W-1:4]};
                carry_d = slice_sum[4];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    state_d = StDone;
                    q_d     = r_shift;
                    cout_d  = slice_sum[4];
                    ovf_d   = slice_c3 ^ slice_sum[4];
                end
            end
            StDone: begin
                if (start) capture = 1'b1;
                else       state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            state_d = StAdd;
            sa_d    = A;
            sb_d    = sub ? ~B : B;
            carry_d = sub;
            cnt_d   = '0;
        end

        busy_d = (state_d == StAdd);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4): vector table, handshake corner
// sequences and randomized operations against an arithmetic reference model.
module tb_nibble_add_seq;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset, start, sub;
    logic [W-1:0] a, b, q;
    logic         busy, done, cout, ovf;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.NIBBLES(N)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .sub  (sub),
        .A    (a),
        .B    (b),
        .busy (busy),
        .done (done),
        .Q    (q),
        .cout (cout),
        .ovf  (ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] q;
        logic        c;
        logic        o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, unsigned carry/borrow and signed range test.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                  output logic [15:0] r, output logic c, output logic o);
        int ux, uy, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            r  = 16'(ux + uy);
            c  = (ux + uy) > 65535;
            sr = sx + sy;
        end else begin
            r  = 16'(ux - uy);
            c  = (ux >= uy);
            sr = sx - sy;
        end
        o = (sr > 32767) || (sr < -32768);
    endfunction

    // Issue one start, watch 10 cycles; optionally pulse start again at cycle poke_n.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input int poke_n, input logic [15:0] px, input logic [15:0] py,
                          output logic [15:0] rq, output logic rc, output logic ro,
                          output int lat, output int ndone, output int nbusy,
                          output logic [15:0] q_end);
        lat = 0; ndone = 0; nbusy = 0; rq = '0; rc = 1'b0; ro = 1'b0;
        @(negedge clk);
        start = 1'b1; a = x; b = y; sub = s;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = n; rq = q; rc = cout; ro = ovf;
                end
            end
            if (busy) nbusy++;
            start = (n == poke_n);
            if (n == poke_n) begin
                a = px; b = py; sub = ~s;
            end else begin
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            end
        end
        q_end = q;
    endtask

    initial begin
        vec_t        vecs[7];
        logic [15:0] rq, q_end, eq;
        logic        rc, ro, ec, eo;
        int          lat, ndone, nbusy, dcount;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset held two cycles with start asserted.
        reset = 1'b1; start = 1'b1; sub = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_q", q, 0);
        check("rst_cout", cout, 0); check("rst_ovf", ovf, 0);
        check("rst_idle", busy | done, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, 16'h0, 16'h0,
                   rq, rc, ro, lat, ndone, nbusy, q_end);
            check($sformatf("vec%0d_q", i), rq, vecs[i].q);
            check($sformatf("vec%0d_cout", i), rc, vecs[i].c);
            check($sformatf("vec%0d_ovf", i), ro, vecs[i].o);
            check($sformatf("vec%0d_lat", i), lat, 5);
            check($sformatf("vec%0d_ndone", i), ndone, 1);
            check($sformatf("vec%0d_nbusy", i), nbusy, 4);
            check($sformatf("vec%0d_qhold", i), q_end, vecs[i].q);
        end

        // Start pulsed while busy must be dropped.
        run_op(16'h1234, 16'h0FCD, 1'b0, 2, 16'h4444, 16'h1111,
               rq, rc, ro, lat, ndone, nbusy, q_end);
        check("ign_q", rq, 16'h2201);
        check("ign_lat", lat, 5);
        check("ign_ndone", ndone, 1);
        check("ign_qhold", q_end, 16'h2201);

        // Start held across two operations: second accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
        dcount = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done) dcount++;
            if (n == 5) begin
                check("bb_done5", done, 1); check("bb_q1", q, 16'h3333);
                check("bb_c1", cout, 0); check("bb_o1", ovf, 0);
            end
            if (n == 6) check("bb_busy6", busy, 1);
            if (n == 10) begin
                check("bb_done10", done, 1); check("bb_q2", q, 16'h8000);
                check("bb_c2", cout, 1); check("bb_o2", ovf, 0);
            end
            if (n == 1) begin a = 16'h9000; b = 16'h1000; sub = 1'b1; end
            if (n == 6) start = 1'b0;
        end
        check("bb_dcount", dcount, 2);

        // Reset on the second ADD cycle aborts the operation.
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h0FCD; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0); check("abort_done", done, 0);
        check("abort_q", q, 0); check("abort_cout", cout, 0); check("abort_ovf", ovf, 0);
        reset = 1'b0;
        dcount = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("abort_quiet", dcount, 0);
        run_op(16'h1234, 16'h0FCD, 1'b0, 0, 16'h0, 16'h0, rq, rc, ro, lat, ndone, nbusy, q_end);
        check("after_abort_q", rq, 16'h2201);
        check("after_abort_lat", lat, 5);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [15:0] x, y;
            logic        s;
            x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
            if (i % 5 == 0) y = x;
            model(x, y, s, eq, ec, eo);
            run_op(x, y, s, 0, 16'h0, 16'h0, rq, rc, ro, lat, ndone, nbusy, q_end);
            check($sformatf("rnd%0d_q", i), rq, eq);
            check($sformatf("rnd%0d_cout", i), rc, ec);
            check($sformatf("rnd%0d_ovf", i), ro, eo);
            check($sformatf("rnd%0d_lat", i), lat, 5);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
